// File: rtl/slice_frame_packer.sv
// Packs a stream of SLICE_W-bit slices into a NUM_SLOTS-slot frame register and
// presents each finished frame (full or closed early by s_last) on a valid/ready output.
module slice_frame_packer #(
    parameter int SLICE_W   = 24,
    parameter int NUM_SLOTS = 64,
    parameter int IDX_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [SLICE_W-1:0]           s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [SLICE_W*NUM_SLOTS-1:0] m_data,
    output logic [IDX_W:0]               m_count,
    output logic [IDX_W-1:0]             m_idx
);

    localparam int FRAME_W = SLICE_W * NUM_SLOTS;
    localparam int OFF_W   = ($clog2(FRAME_W) > 11) ? $clog2(FRAME_W) : 11;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [IDX_W-1:0]     r_wrPtr;
    logic [FRAME_W-1:0]   r_frame;
    logic [IDX_W:0]       r_count;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_sReady;
    logic                 w_mValid;
    logic                 w_accept;
    logic                 w_closeFrame;
    logic                 w_release;
    logic                 w_lastSlot;
    logic [OFF_W-1:0]     w_offset;

    // Both operands are widened before the multiply so the slot offset never truncates.
    assign w_offset   = OFF_W'(r_wrPtr) * OFF_W'(SLICE_W);
    assign w_lastSlot = (r_wrPtr == IDX_W'(NUM_SLOTS - 1));

    always_comb begin
        w_nextState  = r_state;
        w_sReady     = 1'b0;
        w_mValid     = 1'b0;
        w_accept     = 1'b0;
        w_closeFrame = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            FILL: begin
                w_sReady = 1'b1;
                w_accept = s_valid;
                if (s_valid && (w_lastSlot || s_last)) begin
                    w_closeFrame = 1'b1;
                    w_nextState  = HOLD;
                end
            end
            HOLD: begin
                w_mValid = 1'b1;
                if (m_ready) begin
                    w_release   = 1'b1;
                    w_nextState = FILL;
                end
            end
            default: begin
                w_nextState = FILL;
            end
        endcase
    end

    // The frame is cleared on release so unwritten slots of the next short frame read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_wrPtr <= '0;
            r_frame <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_release) begin
                r_frame <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
                r_idx   <= '0;
            end else if (w_accept) begin
                r_frame[w_offset +: SLICE_W] <= s_data;
                r_wrPtr <= r_wrPtr + IDX_W'(1);
                if (w_closeFrame) begin
                    r_count <= (IDX_W+1)'(r_wrPtr) + (IDX_W+1)'(1);
                    r_idx   <= r_wrPtr;
                end
            end
        end
    end

    assign s_ready = w_sReady;
    assign m_valid = w_mValid;
    assign m_data  = r_frame;
    assign m_count = r_count;
    assign m_idx   = r_idx;

endmodule

// File: tb/tb_slice_frame_packer.sv
// Directed testbench for slice_frame_packer: builds expected frames locally and
// compares outputs slot by slot after each frame completes.
module tb_slice_frame_packer;

   localparam int SLICE_W   = 24;
   localparam int NUM_SLOTS = 64;
   localparam int IDX_W     = 6;
   localparam int FRAME_W   = SLICE_W * NUM_SLOTS;

   logic                 clk;
   logic                 rst_n;
   logic                 s_valid;
   logic                 s_ready;
   logic [SLICE_W-1:0]   s_data;
   logic                 s_last;
   logic                 m_valid;
   logic                 m_ready;
   logic [FRAME_W-1:0]   m_data;
   logic [IDX_W:0]       m_count;
   logic [IDX_W-1:0]     m_idx;

   logic [FRAME_W-1:0]   expFrame;
   int                   vectorCount;
   int                   missCount;

   slice_frame_packer #(
      .SLICE_W   (SLICE_W),
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_count (m_count),
      .m_idx   (m_idx)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Compares every slot of the output frame against the locally built frame
   task automatic checkFrame(input string tag);
      for (int k = 0; k < NUM_SLOTS; k++) begin
         checkOutput($sformatf("%s_slot%0d", tag, k),
                     64'(m_data[k*SLICE_W +: SLICE_W]),
                     64'(expFrame[k*SLICE_W +: SLICE_W]));
      end
   endtask

   // Steps one clock and leaves time 1 unit past the rising edge for sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one slice and waits (bounded) until it is accepted, then drops s_valid
   task automatic applyStimulus(input logic [SLICE_W-1:0] data, input logic last);
      bit accepted;
      accepted = 1'b0;
      s_valid  = 1'b1;
      s_data   = data;
      s_last   = last;
      for (int c = 0; c < 200 && !accepted; c++) begin
         if (s_ready) accepted = 1'b1;
         tick();
      end
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Completes the output handshake and checks the packer returns to an empty FILL state
   task automatic releaseFrame(input string tag);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      checkOutput({tag, "_rel_mvalid"}, 64'(m_valid), 64'd0);
      checkOutput({tag, "_rel_sready"}, 64'(s_ready), 64'd1);
      checkOutput({tag, "_rel_count"},  64'(m_count), 64'd0);
      checkOutput({tag, "_rel_zero"},   64'(m_data == '0), 64'd1);
   endtask

   task automatic checkHold(input string tag, input int count);
      checkOutput({tag, "_mvalid"}, 64'(m_valid), 64'd1);
      checkOutput({tag, "_sready"}, 64'(s_ready), 64'd0);
      checkOutput({tag, "_count"},  64'(m_count), 64'(count));
      checkOutput({tag, "_idx"},    64'(m_idx),   64'(count - 1));
      checkFrame(tag);
   endtask

   initial begin
      logic [SLICE_W-1:0] d;
      vectorCount = 0;
      missCount   = 0;
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      expFrame = '0;

      // Reset held for two cycles
      tick();
      tick();
      rst_n = 1'b1;
      checkOutput("rst_mvalid", 64'(m_valid), 64'd0);
      checkOutput("rst_sready", 64'(s_ready), 64'd1);
      checkOutput("rst_count",  64'(m_count), 64'd0);
      checkOutput("rst_idx",    64'(m_idx),   64'd0);
      checkOutput("rst_zero",   64'(m_data == '0), 64'd1);

      // Full frame of k values, m_valid must rise right after the 64th accept
      for (int k = 0; k < NUM_SLOTS; k++) begin
         d = SLICE_W'(k);
         expFrame[k*SLICE_W +: SLICE_W] = d;
         applyStimulus(d, 1'b0);
         if (k == NUM_SLOTS - 2) checkOutput("full_early_mvalid", 64'(m_valid), 64'd0);
      end
      checkHold("full", 64);
      releaseFrame("full");

      // Short frame closed by s_last on the third slice
      expFrame = '0;
      expFrame[71:0] = 72'h0F0F0F_123456_ABCDEF;
      applyStimulus(24'hABCDEF, 1'b0);
      applyStimulus(24'h123456, 1'b0);
      applyStimulus(24'h0F0F0F, 1'b1);
      checkHold("short", 3);

      // Backpressure: a waiting upstream slice must not be consumed in HOLD
      s_valid = 1'b1;
      s_data  = 24'h5A5A5A;
      s_last  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput($sformatf("bp_sready_c%0d", c), 64'(s_ready), 64'd0);
         checkOutput($sformatf("bp_mvalid_c%0d", c), 64'(m_valid), 64'd1);
         checkOutput($sformatf("bp_count_c%0d", c),  64'(m_count), 64'd3);
      end
      checkFrame("bp_hold");
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      checkOutput("bp_rel_mvalid", 64'(m_valid), 64'd0);
      checkOutput("bp_rel_sready", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
      expFrame = '0;
      expFrame[23:0]  = 24'h5A5A5A;
      expFrame[47:24] = 24'h000777;
      applyStimulus(24'h000777, 1'b1);
      checkHold("bp_next", 2);
      releaseFrame("bp_next");

      // Frame isolation: all-ones frame followed by a single-slice frame
      expFrame = '1;
      for (int k = 0; k < NUM_SLOTS; k++) applyStimulus(24'hFFFFFF, 1'b0);
      checkHold("ones", 64);
      releaseFrame("ones");
      expFrame = '0;
      expFrame[0] = 1'b1;
      applyStimulus(24'h000001, 1'b1);
      checkHold("single", 1);
      releaseFrame("single");

      // Reset mid-frame discards the partial frame
      for (int k = 0; k < 10; k++) applyStimulus(SLICE_W'(32'hC00000 + k), 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("mrst_mvalid", 64'(m_valid), 64'd0);
      checkOutput("mrst_sready", 64'(s_ready), 64'd1);
      checkOutput("mrst_zero",   64'(m_data == '0), 64'd1);
      tick();
      checkOutput("mrst_mvalid2", 64'(m_valid), 64'd0);
      expFrame = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         d = SLICE_W'(32'h100000 + k);
         expFrame[k*SLICE_W +: SLICE_W] = d;
         applyStimulus(d, 1'b0);
      end
      checkHold("mrst", 64);
      releaseFrame("mrst");

      // Idle gaps: roughly 30% valid duty with random payloads
      expFrame = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         for (int g = 0; g < 20 && $urandom_range(0, 99) >= 30; g++) begin
            tick();
            checkOutput($sformatf("gap_mvalid_s%0d", k), 64'(m_valid), 64'd0);
         end
         d = SLICE_W'($urandom);
         expFrame[k*SLICE_W +: SLICE_W] = d;
         applyStimulus(d, 1'b0);
      end
      checkHold("gaps", 64);
      releaseFrame("gaps");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
